// File: rtl/transmitter.sv
// rtl/transmitter.sv - serial frame transmitter: 32-bit word, MSB first, framed by com_en_out
module transmitter #(
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        data_out,
  output logic        com_en_out,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frames_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] BIT_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [31:0] shift_q;
  logic [31:0] buf_q;
  logic        buf_full_q;
  logic [4:0]  bit_cnt_q;
  logic [7:0]  cyc_cnt_q;
  logic        com_en_q;
  logic        frame_done_q;
  logic [15:0] frames_q;

  logic        load_accept;
  logic        bit_wrap;
  logic        last_bit;
  logic        gap_wrap;
  logic [7:0]  cyc_cnt_d;
  logic [4:0]  bit_cnt_d;
  logic [31:0] shift_d;
  logic [15:0] frames_d;

  // Handshake, counter terminal conditions and incremented values
  always_comb begin
    load_accept = load_valid & ~buf_full_q;
    bit_wrap    = (cyc_cnt_q == BIT_LAST);
    last_bit    = (bit_cnt_q == 5'd31);
    gap_wrap    = (cyc_cnt_q == GAP_LAST);
    cyc_cnt_d   = cyc_cnt_q + 8'd1;
    bit_cnt_d   = bit_cnt_q + 5'd1;
    shift_d     = {shift_q[30:0], 1'b0};
    frames_d    = frames_q + 16'd1;
  end

  // Frame sequencer: IDLE -> SEND (32 bits) -> GAP -> SEND or IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= 32'd0;
      buf_q        <= 32'd0;
      buf_full_q   <= 1'b0;
      bit_cnt_q    <= 5'd0;
      cyc_cnt_q    <= 8'd0;
      com_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frames_q     <= 16'd0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (buf_full_q) begin
            shift_q    <= buf_q;
            buf_full_q <= 1'b0;
            state_q    <= SEND;
            com_en_q   <= 1'b1;
            cyc_cnt_q  <= 8'd0;
            bit_cnt_q  <= 5'd0;
          end else if (load_accept) begin
            shift_q   <= load_data;
            state_q   <= SEND;
            com_en_q  <= 1'b1;
            cyc_cnt_q <= 8'd0;
            bit_cnt_q <= 5'd0;
          end
        end
        SEND: begin
          if (load_accept) begin
            buf_q      <= load_data;
            buf_full_q <= 1'b1;
          end
          if (bit_wrap) begin
            cyc_cnt_q <= 8'd0;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            if (last_bit) begin
              state_q      <= GAP;
              com_en_q     <= 1'b0;
              frame_done_q <= 1'b1;
              frames_q     <= frames_d;
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_d;
          end
        end
        GAP: begin
          if (gap_wrap) begin
            cyc_cnt_q <= 8'd0;
            bit_cnt_q <= 5'd0;
            if (buf_full_q) begin
              shift_q    <= buf_q;
              buf_full_q <= 1'b0;
              state_q    <= SEND;
              com_en_q   <= 1'b1;
            end else if (load_accept) begin
              shift_q  <= load_data;
              state_q  <= SEND;
              com_en_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_d;
            if (load_accept) begin
              buf_q      <= load_data;
              buf_full_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          com_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready  = ~buf_full_q;
  assign busy        = (state_q != IDLE) | buf_full_q;
  assign com_en_out  = com_en_q;
  assign data_out    = com_en_q & shift_q[31];
  assign frame_done  = frame_done_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_transmitter.sv
// tb/tb_transmitter.sv - self-checking bench for transmitter
module tb_transmitter;

  localparam int BC  = 4;
  localparam int GAP = 8;

  logic        clk;
  logic        reset;
  logic [31:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic        data_out;
  logic        com_en_out;
  logic        busy;
  logic        frame_done;
  logic [15:0] frames_sent;

  transmitter #(.BIT_CYCLES(BC), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_out   (data_out),
    .com_en_out (com_en_out),
    .busy       (busy),
    .frame_done (frame_done),
    .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: queue of expected output samples, one per future cycle
  typedef struct packed {
    logic en;
    logic d;
    logic done;
  } samp_t;

  samp_t       mq[$];
  logic [31:0] mpend;
  bit          mpend_v = 0;
  logic [15:0] mcount  = 16'd0;

  function automatic void push_frame(input logic [31:0] w);
    samp_t s;
    for (int i = 31; i >= 0; i--) begin
      for (int c = 0; c < BC; c++) begin
        s.en = 1'b1; s.d = w[i]; s.done = 1'b0;
        mq.push_back(s);
      end
    end
    for (int g = 0; g < GAP; g++) begin
      s.en = 1'b0; s.d = 1'b0; s.done = (g == 0);
      mq.push_back(s);
    end
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      mq.delete();
      mpend_v = 0;
      mcount  = 16'd0;
    end else begin
      acc = load_valid && !mpend_v;
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        mpend   = load_data;
        mpend_v = 1;
      end
      if (mq.size() == 0 && mpend_v) begin
        push_frame(mpend);
        mpend_v = 0;
      end
      if (mq.size() > 0 && mq[0].done) mcount = mcount + 16'd1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    samp_t s;
    if (chk_en) begin
      s = (mq.size() > 0) ? mq[0] : samp_t'(3'b000);
      check("cyc_com_en",      {31'd0, com_en_out}, {31'd0, s.en});
      check("cyc_data_out",    {31'd0, data_out},   {31'd0, s.d});
      check("cyc_frame_done",  {31'd0, frame_done}, {31'd0, s.done});
      check("cyc_busy",        {31'd0, busy},       {31'd0, (mq.size() > 0) || mpend_v});
      check("cyc_load_ready",  {31'd0, load_ready}, {31'd0, !mpend_v});
      check("cyc_frames_sent", {16'd0, frames_sent}, {16'd0, mcount});
    end
  end

  // Receiver-side monitor: rebuilds words and measures frame and gap lengths
  int          hi_len = 0;
  int          lo_len = 0;
  logic [31:0] rx_word = 32'd0;
  bit          prev_en = 0;
  bit          seen_frame = 0;
  int          done_cnt = 0;
  int          fr_len[$];
  logic [31:0] fr_word[$];
  int          gap_len[$];

  always @(negedge clk) begin
    if (chk_en) begin
      if (com_en_out === 1'b1) begin
        if (!prev_en) begin
          if (seen_frame) gap_len.push_back(lo_len);
          hi_len  = 0;
          rx_word = 32'd0;
        end
        hi_len++;
        if (((hi_len - 1) % BC) == (BC / 2)) rx_word = {rx_word[30:0], data_out};
        prev_en = 1;
      end else begin
        if (prev_en) begin
          fr_len.push_back(hi_len);
          fr_word.push_back(rx_word);
          seen_frame = 1;
          lo_len = 0;
        end
        lo_len++;
        prev_en = 0;
      end
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic mon_clear();
    fr_len.delete();
    fr_word.delete();
    gap_len.delete();
    seen_frame = 0;
    done_cnt   = 0;
  endtask

  task automatic load(input logic [31:0] w);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < budget);
    check("wait_idle", {31'd0, busy}, 32'd0);
    #1;
  endtask

  task automatic wait_en(input logic lvl, input int budget);
    int k;
    k = 0;
    while (com_en_out !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_com_en", {31'd0, com_en_out}, {31'd0, lvl});
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int k;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 32'd0;
    @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    check("rst_load_ready",  {31'd0, load_ready}, 32'd1);
    check("rst_busy",        {31'd0, busy}, 32'd0);
    check("rst_com_en",      {31'd0, com_en_out}, 32'd0);
    check("rst_data_out",    {31'd0, data_out}, 32'd0);
    check("rst_frame_done",  {31'd0, frame_done}, 32'd0);
    check("rst_frames_sent", {16'd0, frames_sent}, 32'd0);
    reset = 1'b0;
    #1 mon_clear();

    // Single frame
    load(32'hA5A5_0F0F);
    wait_en(1'b0, 200);
    k = 1;
    while (busy === 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("busy_low_after_frame", k, 32'd9);
    wait_idle(1000);
    check("t1_frame_count", fr_word.size(), 32'd1);
    check("t1_len",         fr_len[0], 32'd128);
    check("t1_word",        fr_word[0], 32'hA5A5_0F0F);
    check("t1_done_pulses", done_cnt, 32'd1);
    check("t1_frames_sent", {16'd0, frames_sent}, 32'd1);
    mon_clear();

    // Back-to-back with an ignored overflow load
    load(32'h8000_0001);
    load(32'h1234_5678);
    check("t2_ready_low", {31'd0, load_ready}, 32'd0);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    load_data  = 32'h5A5A_5A5A;
    wait_en(1'b0, 200);
    wait_en(1'b1, 50);
    check("t2_ready_at_second_start", {31'd0, load_ready}, 32'd1);
    wait_idle(1000);
    check("t2_frame_count", fr_word.size(), 32'd2);
    check("t2_word0",       fr_word[0], 32'h8000_0001);
    check("t2_word1",       fr_word[1], 32'h1234_5678);
    check("t2_gap",         gap_len[0], 32'd8);
    check("t2_len1",        fr_len[1], 32'd128);
    check("t2_frames_sent", {16'd0, frames_sent}, 32'd3);
    mon_clear();

    // Reset at cycle 50 of a frame, with a simultaneous load that must be dropped
    load(32'hC3C3_3C3C);
    repeat (49) @(negedge clk);
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'h1111_1111;
    @(negedge clk);
    reset      = 1'b0;
    load_valid = 1'b0;
    check("t3_com_en_after_rst", {31'd0, com_en_out}, 32'd0);
    check("t3_busy_after_rst",   {31'd0, busy}, 32'd0);
    check("t3_ready_after_rst",  {31'd0, load_ready}, 32'd1);
    check("t3_frames_after_rst", {16'd0, frames_sent}, 32'd0);
    #1;
    check("t3_aborted_len", fr_len[0], 32'd50);
    check("t3_no_done",     done_cnt, 32'd0);
    mon_clear();
    load(32'h0F0F_F0F0);
    wait_idle(1000);
    check("t3_frame_count", fr_word.size(), 32'd1);
    check("t3_word",        fr_word[0], 32'h0F0F_F0F0);
    check("t3_len",         fr_len[0], 32'd128);
    check("t3_frames_sent", {16'd0, frames_sent}, 32'd1);
    mon_clear();

    // Loopback words
    load(32'h0000_0000);
    load(32'hFFFF_FFFF);
    k = 0;
    while (load_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("t4_ready_return", {31'd0, load_ready}, 32'd1);
    load(32'h1357_9BDF);
    wait_idle(2000);
    check("t4_frame_count", fr_word.size(), 32'd3);
    check("t4_word0", fr_word[0], 32'h0000_0000);
    check("t4_word1", fr_word[1], 32'hFFFF_FFFF);
    check("t4_word2", fr_word[2], 32'h1357_9BDF);
    check("t4_gap0",  gap_len[0], 32'd8);
    check("t4_gap1",  gap_len[1], 32'd8);
    check("t4_frames_sent", {16'd0, frames_sent}, 32'd4);
    mon_clear();

    // frames_sent wrap
    @(posedge clk);
    #2;
    force dut.frames_q = 16'hFFFF;
    mcount = 16'hFFFF;
    #1;
    release dut.frames_q;
    @(negedge clk);
    check("t5_preload", {16'd0, frames_sent}, 32'h0000_FFFF);
    load(32'h2468_ACE0);
    wait_idle(1000);
    check("t5_word",  fr_word[0], 32'h2468_ACE0);
    check("t5_wrap",  {16'd0, frames_sent}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
